// File: rtl/bounce_emulator.sv
// bounce_emulator: four-channel contact-bounce generator driven by
// a shared 16-bit Galois LFSR; registered pass-through when disabled.
module bounce_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 50000,
    parameter int unsigned MIN_TOGGLE    = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] dataClean,
    output logic [3:0] dataBouncy,
    output logic [3:0] busy
);

    typedef enum logic {
        STABLE,
        BOUNCE
    } state_t;

    localparam logic [19:0] WIN_LOAD = 20'(BOUNCE_CYCLES - 1);
    localparam logic [8:0]  MIN_T    = 9'(MIN_TOGGLE);
    localparam logic [15:0] MASK     = 16'hB400;

    logic [15:0] lfsr;

    // free-running right-shift Galois LFSR, never zero from a non-zero seed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? MASK : 16'h0000);
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        state_t      state;
        logic        target;
        logic        q;
        logic        bsy;
        logic [19:0] win;
        logic [8:0]  tog;
        logic [8:0]  interval;

        assign interval = MIN_T + {5'b0, lfsr[4*gi +: 4]};
        assign dataBouncy[gi] = q;
        assign busy[gi] = bsy;

        // per-channel STABLE/BOUNCE machine; a new level always restarts the window
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state  <= STABLE;
                target <= 1'b0;
                q      <= 1'b0;
                bsy    <= 1'b0;
                win    <= '0;
                tog    <= '0;
            end else if (!enable) begin
                state  <= STABLE;
                target <= dataClean[gi];
                q      <= dataClean[gi];
                bsy    <= 1'b0;
                win    <= '0;
                tog    <= '0;
            end else if (dataClean[gi] != target) begin
                state  <= BOUNCE;
                target <= dataClean[gi];
                q      <= dataClean[gi];
                bsy    <= 1'b1;
                win    <= WIN_LOAD;
                tog    <= interval;
            end else begin
                unique case (state)
                    STABLE: begin
                        q   <= target;
                        bsy <= 1'b0;
                    end
                    BOUNCE: begin
                        if (win == 20'd0) begin
                            state <= STABLE;
                            q     <= target;
                            bsy   <= 1'b0;
                        end else begin
                            win <= win - 20'd1;
                            bsy <= 1'b1;
                            if (tog == 9'd0) begin
                                q   <= ~q;
                                tog <= interval;
                            end else begin
                                tog <= tog - 9'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bounce_emulator.sv
// tb_bounce_emulator: directed checks of window timing, first-toggle
// position, restart, pass-through, reset and simultaneous channels.
module tb_bounce_emulator;

    localparam int unsigned BC   = 100;
    localparam int unsigned MIN  = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] dataClean;
    logic [3:0] dataBouncy;
    logic [3:0] busy;

    int tests;
    int fails;

    logic [15:0] m;

    bounce_emulator #(
        .BOUNCE_CYCLES(BC),
        .MIN_TOGGLE   (MIN),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dataClean (dataClean),
        .dataBouncy(dataBouncy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference LFSR built from the polynomial x^16+x^14+x^13+x^11+1
    always @(posedge clk or posedge reset) begin
        if (reset) m <= SEED;
        else m <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear();
        enable = 1'b0;
        dataClean = 4'h0;
        step();
        enable = 1'b1;
        step();
    endtask

    // channels in mask go 0->1 from a settled all-zero state
    task automatic first_toggle(input logic [3:0] mask);
        int iv [4];
        logic [3:0] ok;
        logic busy_ok;
        logic idle_ok;
        logic hold_ok;
        for (int i = 0; i < 4; i++)
            iv[i] = int'(MIN) + int'((m >> (4 * i)) & 16'h000F);
        dataClean = mask;
        step();
        check("detect_q", dataBouncy, mask);
        check("detect_busy", busy, mask);
        ok = 4'hF;
        busy_ok = 1'b1;
        idle_ok = 1'b1;
        for (int k = 1; k < int'(BC); k++) begin
            step();
            if (busy !== mask) busy_ok = 1'b0;
            if ((dataBouncy & ~mask) !== 4'h0) idle_ok = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (k <= iv[i] && dataBouncy[i] !== 1'b1) ok[i] = 1'b0;
                    if (k == iv[i] + 1 && dataBouncy[i] !== 1'b0) ok[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++)
            if (mask[i]) check($sformatf("first_toggle_ch%0d", i), ok[i], 1);
        check("window_busy", busy_ok, 1);
        check("other_bits_idle", idle_ok, 1);
        step();
        check("settle_q", dataBouncy, mask);
        check("settle_busy", busy, 0);
        hold_ok = 1'b1;
        repeat (20) begin
            step();
            if (dataBouncy !== mask || busy !== 4'h0) hold_ok = 1'b0;
        end
        check("settle_hold", hold_ok, 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        enable = 1'b1;
        dataClean = 4'h0;
        #2;
        check("rst_q", dataBouncy, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        steps(3);
        check("idle_q", dataBouncy, 0);
        check("idle_busy", busy, 0);

        // single channel 0->1 window
        first_toggle(4'b0001);

        // second channel starts halfway through channel 0's window
        clear();
        dataClean = 4'b0001;
        step();
        steps(49);
        dataClean = 4'b0011;
        step();
        check("t3_start_busy", busy, 4'b0011);
        check("t3_b1_first", dataBouncy[1], 1);
        steps(49);
        check("t3_k99_busy", busy, 4'b0011);
        step();
        check("t3_b0_settle_busy", busy, 4'b0010);
        check("t3_b0_settle_q", dataBouncy[0], 1);
        steps(49);
        check("t3_k149_busy", busy, 4'b0010);
        step();
        check("t3_b1_settle_busy", busy, 0);
        check("t3_b1_settle_q", dataBouncy, 4'b0011);

        // level reverses mid-window, window restarts
        clear();
        dataClean = 4'b0001;
        step();
        steps(39);
        dataClean = 4'b0000;
        step();
        check("t4_restart_q", dataBouncy, 0);
        check("t4_restart_busy", busy, 4'b0001);
        steps(60);
        check("t4_k100_busy", busy, 4'b0001);
        steps(39);
        check("t4_k139_busy", busy, 4'b0001);
        step();
        check("t4_settle_busy", busy, 0);
        check("t4_settle_q", dataBouncy, 0);

        // disabled pass-through with one cycle of latency
        enable = 1'b0;
        for (int v = 1; v < 16; v++) begin
            dataClean = 4'(v);
            step();
            check($sformatf("pass_%0d", v), {busy, dataBouncy}, {4'h0, 4'(v)});
        end

        // disabling abandons an open window at once
        enable = 1'b1;
        dataClean = 4'h0;
        step();
        check("abandon_open_busy", busy, 4'hF);
        steps(5);
        enable = 1'b0;
        dataClean = 4'h5;
        step();
        check("abandon_busy", busy, 0);
        check("abandon_q", dataBouncy, 4'h5);

        // asynchronous reset in an open window, then LFSR restarts at seed
        clear();
        dataClean = 4'b0001;
        step();
        steps(30);
        reset = 1'b1;
        #1;
        check("async_rst_q", dataBouncy, 0);
        check("async_rst_busy", busy, 0);
        step();
        reset = 1'b0;
        check("post_rst_interval", m[3:0], 4'h1);
        first_toggle(4'b0001);

        // all channels change together, each with its own interval
        clear();
        first_toggle(4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bounce_emulator.md
BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 50000: bounce window length in clk cycles (0.5 ms at 100 MHz); legal range 1..2^20-1.
REQ-002 Parameter MIN_TOGGLE, default 16: minimum clk cycles between two toggles inside a bounce window; legal range 1..255.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be non-zero.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = emulate bounce; 0 = registered pass-through.
REQ-007 dataClean  input  4  clean per-channel levels, synchronous to clk.
REQ-008 dataBouncy  output  4  emulated contact signal, for the Debouncer dataSource input; registered.
REQ-009 busy  output  4  per-channel flag, 1 while that channel is in its bounce window; registered.

Function
REQ-010 Each channel shall be an independent two-state FSM: STABLE, BOUNCE.
REQ-011 Each channel shall hold a target register; a change is detected when dataClean[i] differs from target[i] at a rising edge.
REQ-012 STABLE, no change: dataBouncy[i] = target[i]; busy[i] = 0.
REQ-013 STABLE, change detected (enable=1): at that edge target[i] and dataBouncy[i] take the new level (first contact), window counter loads BOUNCE_CYCLES-1, toggle timer loads the current interval, busy[i] goes 1, state goes to BOUNCE.
REQ-014 BOUNCE: window counter decrements by 1 per cycle; toggle timer decrements by 1 per cycle.
REQ-015 BOUNCE, toggle timer = 0 and window counter != 0: dataBouncy[i] inverts; toggle timer reloads the current interval.
REQ-016 Interval = MIN_TOGGLE + 4-bit LFSR slice: channel 0 bits[3:0], channel 1 bits[7:4], channel 2 bits[11:8], channel 3 bits[15:12]; range MIN_TOGGLE..MIN_TOGGLE+15.
REQ-017 BOUNCE, window counter = 0: dataBouncy[i] = target[i] (overrides any toggle in that cycle); busy[i] = 0; state goes to STABLE.
REQ-018 Settle timing: dataBouncy[i] equals target[i] and busy[i] = 0 exactly BOUNCE_CYCLES edges after the detecting edge, and stays there until the next change.
REQ-019 Change detected while in BOUNCE: target[i] updates; the window counter and toggle timer reload as in REQ-013; dataBouncy[i] takes the new level at that edge (window restarts).
REQ-020 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advances every clk cycle regardless of enable; never reaches zero.
REQ-021 enable = 0: every channel forces STABLE, busy = 0, target[i] <= dataClean[i], dataBouncy[i] <= dataClean[i] (1-cycle latency); an open window is abandoned without settling delay.
REQ-022 enable 0->1: no bounce starts for levels already equal to target; only later changes bounce.
REQ-023 Simultaneous changes on several channels shall each start their own window in the same cycle; channels never interact except through the shared LFSR.
REQ-024 Counter widths: window counter 20 bits; toggle timer 9 bits; no wrap-around in any legal configuration.

Reset
REQ-025 While reset is high: dataBouncy = 4'b0000, busy = 4'b0000, target = 4'b0000, all FSMs in STABLE, counters = 0, LFSR = LFSR_SEED.
REQ-026 After reset release, dataClean already non-zero counts as a change on the first edge with enable = 1 and starts a window.
REQ-027 Reset asserted mid-window shall return the channel to the REQ-025 values immediately, asynchronously, with no settling behaviour.

Verification (BOUNCE_CYCLES=100, MIN_TOGGLE=4, enable=1 unless stated)
REQ-028 dataClean 0->4'b0001 -> dataBouncy[0]=1 at detecting edge, >=1 toggle within 100 cycles, dataBouncy=4'b0001 and busy=0 at edge 100 and stable after; other bits stay 0.
REQ-029 dataClean 4'b0001->4'b0011 at edge 50 of bit-0's window -> bit 0 untouched, bit 1 starts a full 100-cycle window; busy=4'b0010 until it settles.
REQ-030 Bit 0 toggled 1->0 at edge 40 of its window -> window restarts, settles to 0 at 100 edges after the second change.
REQ-031 enable=0, dataClean sequence 1,2,...,15 one value per cycle -> dataBouncy equals dataClean delayed 1 cycle, busy=0 throughout.
REQ-032 Reset pulse at edge 30 of an open window -> dataBouncy=0 and busy=0 immediately; LFSR restarts at 16'hACE1.
REQ-033 Chained with Debouncer (maxCount 100000), BOUNCE_CYCLES=50000, dataClean stepped 1..15 every 2 ms -> dataDebounced shows each value exactly once, no glitch values.
